// File: rtl/branch_predictor.sv
// ============================================================================
// Module  : branch_predictor
// Brief   : IF-stage 2-bit counter + direct-mapped BTB predictor with ID-stage
//           training and registered mispredict/redirect. Optional macro:
//           BP_GSHARE_EN (XOR global history into the index).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor #(
  parameter int INDEX_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        if_pc,
  output logic               pred_taken,
  output logic [31:0]        pred_target,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               upd_valid,
  input  logic [31:0]        upd_pc,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken,
  input  logic [31:0]        upd_target,
  input  logic               upd_pred_taken,
  input  logic [31:0]        upd_pred_target,
  output logic               mispredict,
  output logic [31:0]        redirect_pc
);

  localparam int c_ENTRIES = 2 ** INDEX_W;
  localparam int c_TAG_W   = 30 - INDEX_W;

  logic [1:0]         r_cnt       [c_ENTRIES];
  logic [c_ENTRIES-1:0] r_btb_valid;
  logic [c_TAG_W-1:0] r_btb_tag   [c_ENTRIES];
  logic [31:0]        r_btb_tgt   [c_ENTRIES];
  logic               r_mispredict;
  logic [31:0]        r_redirect_pc;

  logic [INDEX_W-1:0] w_pc_index;
  logic [INDEX_W-1:0] w_index;
  logic [c_TAG_W-1:0] w_if_tag;
  logic [c_TAG_W-1:0] w_upd_tag;
  logic               w_hit;
  logic [1:0]         w_cnt_cur;
  logic [1:0]         w_cnt_next;
  logic               w_wrong;
  logic [31:0]        w_redirect;
  logic               w_unused_pc;

  assign w_pc_index  = if_pc[INDEX_W+1:2];
  assign w_if_tag    = if_pc[31:INDEX_W+2];
  assign w_upd_tag   = upd_pc[31:INDEX_W+2];
  assign w_unused_pc = ^if_pc[1:0];

`ifdef BP_GSHARE_EN
  logic [INDEX_W-1:0] r_ghr;

  // History is trained only from resolved branches, so it never needs repair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (upd_valid) begin
      r_ghr <= (r_ghr << 1) | INDEX_W'(upd_taken);
    end
  end

  assign w_index = w_pc_index ^ r_ghr;
`else
  assign w_index = w_pc_index;
`endif

  assign w_hit       = r_btb_valid[w_index] && (r_btb_tag[w_index] == w_if_tag);
  assign pred_index  = w_index;
  assign pred_taken  = w_hit && r_cnt[w_index][1];
  assign pred_target = r_btb_tgt[w_index];

  assign w_cnt_cur = r_cnt[upd_index];

  always_comb begin
    w_cnt_next = w_cnt_cur;
    if (upd_taken) begin
      if (w_cnt_cur != 2'b11) w_cnt_next = w_cnt_cur + 2'd1;
    end else begin
      if (w_cnt_cur != 2'b00) w_cnt_next = w_cnt_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_cnt[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      r_cnt[upd_index] <= w_cnt_next;
    end
  end

  // Only taken branches allocate; a not-taken outcome leaves the BTB alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btb_valid <= '0;
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_btb_tag[i] <= '0;
        r_btb_tgt[i] <= '0;
      end
    end else if (upd_valid && upd_taken) begin
      r_btb_valid[upd_index] <= 1'b1;
      r_btb_tag[upd_index]   <= w_upd_tag;
      r_btb_tgt[upd_index]   <= upd_target;
    end
  end

  assign w_wrong = upd_valid &&
                   ((upd_taken != upd_pred_taken) ||
                    (upd_taken && (upd_pred_target != upd_target)));
  assign w_redirect = upd_taken ? upd_target : (upd_pc + 32'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_mispredict <= w_wrong;
      if (w_wrong) r_redirect_pc <= w_redirect;
    end
  end

  assign mispredict  = r_mispredict;
  assign redirect_pc = r_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module  : tb_branch_predictor
// Brief   : Scoreboard bench for branch_predictor with a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

  localparam int IW = 6;
  localparam int N  = 2 ** IW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   if_pc;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic [IW-1:0] pred_index;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic [IW-1:0] upd_index;
  logic          upd_taken;
  logic [31:0]   upd_target;
  logic          upd_pred_taken;
  logic [31:0]   upd_pred_target;
  logic          mispredict;
  logic [31:0]   redirect_pc;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_index(pred_index),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_index(upd_index),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  typedef struct { bit tk; logic [31:0] tgt; int idx; } pred_t;
  typedef struct { bit mis; logic [31:0] rpc; } mis_t;

  pred_t pq[$];
  mis_t  mq[$];
  int    compared   = 0;
  int    mismatched = 0;
  bit    checking   = 0;

  // Reference state: counters as plain integers 0..3, BTB remembers whole PC.
  int          m_cnt [N];
  bit          m_bv  [N];
  logic [31:0] m_bpc [N];
  logic [31:0] m_btgt[N];
  int          m_ghr;
  logic [31:0] m_last_rpc;

  bit          p_v, p_t, p_pt;
  logic [31:0] p_pc, p_tgt, p_ptgt;
  int          p_idx;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 1; m_bv[i] = 0; m_bpc[i] = '0; m_btgt[i] = '0;
    end
    m_ghr = 0;
    m_last_rpc = '0;
  endfunction

  function automatic int model_index(logic [31:0] pc);
    int base;
    base = int'((pc >> 2) % 32'(N));
`ifdef BP_GSHARE_EN
    return base ^ m_ghr;
`else
    return base;
`endif
  endfunction

  function automatic pred_t model_predict(logic [31:0] pc);
    pred_t p;
    p.idx = model_index(pc);
    p.tgt = m_btgt[p.idx];
    p.tk  = m_bv[p.idx] && ((m_bpc[p.idx] >> (IW + 2)) == (pc >> (IW + 2))) &&
            (m_cnt[p.idx] >= 2);
    return p;
  endfunction

  function automatic void model_update(int idx, bit tk, logic [31:0] pc, logic [31:0] tgt);
    if (tk) begin
      m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
      m_bv[idx] = 1; m_bpc[idx] = pc; m_btgt[idx] = tgt;
    end else begin
      m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
    end
    m_ghr = ((m_ghr << 1) | int'(tk)) % N;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  pred_t mon_p;
  mis_t  mon_m;

  always @(negedge clk) begin
    if (checking && rst_n) begin
      if (pq.size() == 0 || mq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL queue_underflow: got pq=%0d mq=%0d expected nonempty", pq.size(), mq.size());
      end else begin
        mon_p = pq.pop_front();
        mon_m = mq.pop_front();
        chk("pred_taken",  {31'b0, pred_taken}, {31'b0, mon_p.tk});
        chk("pred_target", pred_target, mon_p.tgt);
        chk("pred_index",  32'(pred_index), 32'(mon_p.idx));
        chk("mispredict",  {31'b0, mispredict}, {31'b0, mon_m.mis});
        chk("redirect_pc", redirect_pc, mon_m.rpc);
      end
    end
  end

  task automatic cycle(input logic [31:0] ipc, input bit uv, input logic [31:0] upc,
                       input bit ut, input logic [31:0] utg,
                       input bit upt, input logic [31:0] uptg);
    mis_t  m;
    pred_t p;
    @(posedge clk);
    #1;
    m.mis = 0;
    if (p_v) begin
      m.mis = (p_t != p_pt) || (p_t && (p_ptgt != p_tgt));
      if (m.mis) m_last_rpc = p_t ? p_tgt : p_pc + 32'd4;
      model_update(p_idx, p_t, p_pc, p_tgt);
    end
    m.rpc = m_last_rpc;
    mq.push_back(m);
    p_idx = model_index(upc);
    if_pc = ipc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg;
    upd_index = IW'(p_idx);
    p_v = uv; p_t = ut; p_pc = upc; p_tgt = utg; p_pt = upt; p_ptgt = uptg;
    p = model_predict(ipc);
    pq.push_back(p);
    checking = 1;
  endtask

  // Async reset lands mid-cycle, right after a mispredict has been registered.
  task automatic mid_reset();
    @(posedge clk);
    #1;
    checking = 0;
    upd_valid = 0;
    pq.delete();
    mq.delete();
    #2 rst_n = 0;
    model_reset();
    p_v = 0;
    #1;
    chk("rst_mispredict",  {31'b0, mispredict}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_pred_taken",  {31'b0, pred_taken}, 32'd0);
    chk("rst_pred_target", pred_target, 32'd0);
    chk("rst_pred_index",  32'(pred_index), 32'(model_index(if_pc)));
    @(negedge clk);
    #1 rst_n = 1;
  endtask

  logic [31:0] pc_pool  [8] = '{32'h100, 32'h104, 32'h108, 32'h200,
                                32'h204, 32'h300, 32'hFFFF_FFFC, 32'h140};
  logic [31:0] tgt_pool [4] = '{32'h80, 32'h40, 32'h1000, 32'h2000};

  initial begin
    pred_t       rp;
    logic [31:0] rpc, ipc, rtg;
    bit          rt;
    rst_n = 0; if_pc = 32'h100; upd_valid = 0; upd_pc = 0; upd_index = 0;
    upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
    model_reset();
    p_v = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;

    cycle(32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h0);
    cycle(32'h100, 1, 32'h100, 0, 32'h0,  0, 32'h0);
    cycle(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h0);
    cycle(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h0);
    cycle(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h0);
    cycle(32'h200, 0, 32'h0,   0, 32'h0,  0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(32'h108, 1, 32'h108, 1, 32'h40, 1, 32'h40);
    cycle(32'h108, 1, 32'h108, 0, 32'h0, 1, 32'h40);
    cycle(32'h108, 1, 32'h108, 0, 32'h0, 1, 32'h40);
    cycle(32'h108, 0, 32'h0,   0, 32'h0, 0, 32'h0);
    cycle(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h40);
    cycle(32'h100, 1, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10);
    cycle(32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h0);
    cycle(32'h104, 1, 32'h104, 1, 32'h80, 0, 32'h0);
    mid_reset();

    cycle(32'h104, 1, 32'h100, 1, 32'h80, 0, 32'h0);
    cycle(32'h104, 1, 32'h100, 0, 32'h0,  0, 32'h0);
    cycle(32'h104, 0, 32'h0,   0, 32'h0,  0, 32'h0);
    cycle(32'h104, 0, 32'h0,   0, 32'h0,  0, 32'h0);

    for (int n = 0; n < 600; n++) begin
      ipc = ($urandom_range(0, 9) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                        : pc_pool[$urandom_range(0, 7)];
      rpc = pc_pool[$urandom_range(0, 7)];
      rt  = 1'($urandom_range(0, 1));
      rtg = tgt_pool[$urandom_range(0, 3)];
      rp  = model_predict(rpc);
      if ($urandom_range(0, 3) == 0) begin
        rp.tk  = 1'($urandom_range(0, 1));
        rp.tgt = tgt_pool[$urandom_range(0, 3)];
      end
      cycle(ipc, $urandom_range(0, 3) != 0, rpc, rt, rtg, rp.tk, rp.tgt);
    end

    @(posedge clk);
    #1 checking = 0;
    chk("queues_drained", 32'(pq.size() + mq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
